// File: rtl/fht_stage_sequencer.sv
// rtl/fht_stage_sequencer.sv - stage/address sequencer for an in-place radix-2 FHT
// Reads one butterfly per cycle, then drains the datapath before the next stage.
module fht_stage_sequencer #(
  parameter int A_BIT   = 10,
  parameter int LATENCY = 3,
  localparam int STG_BIT = $clog2(A_BIT),
  localparam int LN_BIT  = $clog2(A_BIT + 1)
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iABORT,
  input  logic [LN_BIT-1:0]  iLOG_N,
  output logic               oRD_EN,
  output logic [A_BIT-1:0]   oADDR_RD_0,
  output logic [A_BIT-1:0]   oADDR_RD_1,
  output logic [A_BIT-2:0]   oADDR_COEF,
  output logic [A_BIT-1:0]   oADDR_WR_0,
  output logic [A_BIT-1:0]   oADDR_WR_1,
  output logic               oWE_A,
  output logic               oWE_B,
  output logic               oSRC_BANK,
  output logic [STG_BIT-1:0] oSTAGE,
  output logic               oST_ZERO,
  output logic               oST_LAST,
  output logic               oRES_B,
  output logic               oERR,
  output logic               oRDY
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic             en;
    logic [A_BIT-1:0] a0;
    logic [A_BIT-1:0] a1;
    logic             s0;
  } wr_t;

  state_t             state_q, state_d;
  logic [STG_BIT-1:0] s_q, s_d;
  logic [A_BIT-2:0]   k_q, k_d;
  logic [LN_BIT-1:0]  l_q, l_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush;

  logic [A_BIT-1:0]   half, k_ext, mask, j;
  logic [A_BIT-2:0]   j_sh;
  logic [LN_BIT-1:0]  csh;
  logic               k_last, cnt_last, s_last, bad_len, busy_d;

  logic               rd_en_q, rd_en_d;
  logic [A_BIT-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
  logic [A_BIT-2:0]   coef_q, coef_d;
  logic               src_bank_q, src_bank_d;
  logic [STG_BIT-1:0] stage_q, stage_d;
  logic               st_zero_q, st_zero_d, st_last_q, st_last_d;
  logic               res_b_q, res_b_d, err_q, err_d, rdy_q, rdy_d;

  wr_t                dl_q [LATENCY];
  logic               we_a_q, we_b_q;
  logic [A_BIT-1:0]   wr0_q, wr1_q;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    k_d      = k_q;
    l_d      = l_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    res_b_d  = res_b_q;
    flush    = 1'b0;

    half     = A_BIT'(1) << (l_q - LN_BIT'(1));
    k_last   = ({1'b0, k_q} == (half - A_BIT'(1)));
    cnt_last = (cnt_q == CNT_W'(LATENCY - 1));
    s_last   = (LN_BIT'(s_q) == (l_q - LN_BIT'(1)));
    bad_len  = (iLOG_N < LN_BIT'(2)) || (iLOG_N > LN_BIT'(A_BIT));

    case (state_q)
      IDLE: begin
        if (iSTART && !iABORT) begin
          l_d = iLOG_N;
          if (bad_len) begin
            err_d = 1'b1;
          end else begin
            state_d = READ;
            s_d     = '0;
            k_d     = '0;
            res_b_d = 1'b0;
          end
        end
      end
      READ: begin
        if (k_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + (A_BIT-1)'(1);
        end
      end
      DRAIN: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (s_last) begin
          state_d = IDLE;
          res_b_d = l_q[0];
        end else begin
          state_d = READ;
          s_d     = s_q + STG_BIT'(1);
          k_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && iABORT) begin
      state_d = IDLE;
      res_b_d = 1'b0;
      flush   = 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_q.
    busy_d  = (state_d != IDLE);
    rd_en_d = (state_d == READ);
    k_ext   = {1'b0, k_d};
    mask    = (A_BIT'(1) << s_d) - A_BIT'(1);
    j       = k_ext & mask;
    csh     = l_d - LN_BIT'(1) - LN_BIT'(s_d);
    j_sh    = (A_BIT-1)'(j << csh);

    rd0_d      = rd_en_d ? (((k_ext & ~mask) << 1) | j) : '0;
    rd1_d      = rd_en_d ? (rd0_d | (A_BIT'(1) << s_d)) : '0;
    coef_d     = rd_en_d ? j_sh : '0;
    src_bank_d = busy_d & s_d[0];
    stage_d    = busy_d ? s_d : '0;
    st_zero_d  = busy_d && (s_d == '0);
    st_last_d  = busy_d && (LN_BIT'(s_d) == (l_d - LN_BIT'(1)));
    rdy_d      = ~busy_d;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      l_q        <= '0;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      coef_q     <= '0;
      src_bank_q <= 1'b0;
      stage_q    <= '0;
      st_zero_q  <= 1'b0;
      st_last_q  <= 1'b0;
      res_b_q    <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      wr0_q      <= '0;
      wr1_q      <= '0;
      for (int i = 0; i < LATENCY; i++) dl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      l_q        <= l_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      coef_q     <= coef_d;
      src_bank_q <= src_bank_d;
      stage_q    <= stage_d;
      st_zero_q  <= st_zero_d;
      st_last_q  <= st_last_d;
      res_b_q    <= res_b_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      if (flush) begin
        we_a_q <= 1'b0;
        we_b_q <= 1'b0;
        wr0_q  <= '0;
        wr1_q  <= '0;
        for (int i = 0; i < LATENCY; i++) dl_q[i] <= '0;
      end else begin
        // dl_q[0] mirrors the read registers; the write registers add the last cycle.
        dl_q[0] <= {rd_en_d, rd0_d, rd1_d, s_d[0]};
        for (int i = 1; i < LATENCY; i++) dl_q[i] <= dl_q[i-1];
        we_b_q <= dl_q[LATENCY-1].en & ~dl_q[LATENCY-1].s0;
        we_a_q <= dl_q[LATENCY-1].en & dl_q[LATENCY-1].s0;
        wr0_q  <= dl_q[LATENCY-1].a0;
        wr1_q  <= dl_q[LATENCY-1].a1;
      end
    end
  end

  assign oRD_EN     = rd_en_q;
  assign oADDR_RD_0 = rd0_q;
  assign oADDR_RD_1 = rd1_q;
  assign oADDR_COEF = coef_q;
  assign oADDR_WR_0 = wr0_q;
  assign oADDR_WR_1 = wr1_q;
  assign oWE_A      = we_a_q;
  assign oWE_B      = we_b_q;
  assign oSRC_BANK  = src_bank_q;
  assign oSTAGE     = stage_q;
  assign oST_ZERO   = st_zero_q;
  assign oST_LAST   = st_last_q;
  assign oRES_B     = res_b_q;
  assign oERR       = err_q;
  assign oRDY       = rdy_q;

endmodule

// File: tb/tb_fht_stage_sequencer.sv
// tb/tb_fht_stage_sequencer.sv - scoreboard bench for fht_stage_sequencer
// Expected reads/writes/completions are queued at start time; a negedge monitor consumes them.
module tb_fht_stage_sequencer;

  localparam int A_BIT = 4;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] log_n = '0;

  logic       rd_en, we_a, we_b, src_bank, st_zero, st_last, res_b, err, rdy;
  logic [3:0] rd0, rd1, wr0, wr1;
  logic [2:0] coef;
  logic [1:0] stage;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {int cyc; int a0; int a1; int coef; int s; int l;} rd_ev_t;
  typedef struct {int cyc; int a0; int a1; int bank_b;} wr_ev_t;
  typedef struct {int cyc; int res_b;} dn_ev_t;

  rd_ev_t rd_q[$];
  wr_ev_t wr_q[$];
  dn_ev_t dn_q[$];
  int     err_q[$];
  bit     prev_rdy = 1'b1;

  fht_stage_sequencer #(.A_BIT(A_BIT), .LATENCY(LAT)) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start), .iABORT(abort), .iLOG_N(log_n),
    .oRD_EN(rd_en), .oADDR_RD_0(rd0), .oADDR_RD_1(rd1), .oADDR_COEF(coef),
    .oADDR_WR_0(wr0), .oADDR_WR_1(wr1), .oWE_A(we_a), .oWE_B(we_b),
    .oSRC_BANK(src_bank), .oSTAGE(stage), .oST_ZERO(st_zero), .oST_LAST(st_last),
    .oRES_B(res_b), .oERR(err), .oRDY(rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: butterfly k of stage s pairs (k/h)*2h + k%h with +h; twiddle index scaled to N.
  task automatic push_events(input int l, input int e, input int a, output int d);
    int half, slen, c, h, a0;
    if (l < 2 || l > A_BIT) begin
      err_q.push_back(e);
      d = e;
      return;
    end
    half = 1 << (l - 1);
    slen = half + LAT;
    for (int s = 0; s < l; s++) begin
      h = 1 << s;
      for (int k = 0; k < half; k++) begin
        c  = e + s * slen + k;
        a0 = (k / h) * 2 * h + (k % h);
        if (a == 0 || c < e + a)
          rd_q.push_back('{c, a0, a0 + h, (k % h) * (1 << (l - 1 - s)), s, l});
        if (a == 0 || c + LAT < e + a)
          wr_q.push_back('{c + LAT, a0, a0 + h, (s % 2 == 0) ? 1 : 0});
      end
    end
    if (a == 0) begin
      d = e + l * slen;
      dn_q.push_back('{d, l % 2});
    end else begin
      d = e + a;
      dn_q.push_back('{d, 0});
    end
  endtask

  // a: abort edge offset from first read cycle (0 = none); p: stray start offset (0 = none).
  task automatic run(input int l, input int a, input int p);
    int e, d;
    e = cyc + 1;
    push_events(l, e, a, d);
    log_n = 3'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < d) begin
      start = (p > 0 && cyc == e + p - 1);
      abort = (a > 0 && cyc == e + a - 1);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  always @(negedge clk) begin
    rd_ev_t rev;
    wr_ev_t wev;
    dn_ev_t dev;
    int     ec;
    if (rst) begin
      prev_rdy = 1'b1;
    end else begin
      if (rd_en) begin
        if (rd_q.size() == 0) check("unexpected_read", 1, 0);
        else begin
          rev = rd_q.pop_front();
          check("rd_cycle", cyc, rev.cyc);
          check("rd_addr0", rd0, rev.a0);
          check("rd_addr1", rd1, rev.a1);
          check("rd_coef", coef, rev.coef);
          check("stage", stage, rev.s);
          check("st_zero", st_zero, (rev.s == 0) ? 1 : 0);
          check("st_last", st_last, (rev.s == rev.l - 1) ? 1 : 0);
          check("src_bank", src_bank, rev.s % 2);
          check("rdy_busy", rdy, 0);
        end
      end else begin
        check("rd_idle_zero", {rd0, rd1, coef}, 0);
      end
      check("we_exclusive", we_a & we_b, 0);
      if (we_a || we_b) begin
        if (wr_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          wev = wr_q.pop_front();
          check("wr_cycle", cyc, wev.cyc);
          check("wr_addr0", wr0, wev.a0);
          check("wr_addr1", wr1, wev.a1);
          check("we_b", we_b, wev.bank_b);
          check("we_a", we_a, 1 - wev.bank_b);
        end
      end else begin
        check("wr_idle_zero", {wr0, wr1}, 0);
      end
      if (rdy && !prev_rdy) begin
        if (dn_q.size() == 0) check("unexpected_rdy_rise", 1, 0);
        else begin
          dev = dn_q.pop_front();
          check("rdy_cycle", cyc, dev.cyc);
          check("res_b", res_b, dev.res_b);
          check("done_flags", {stage, st_zero, st_last}, 0);
        end
      end
      if (err) begin
        if (err_q.size() == 0) check("unexpected_err", 1, 0);
        else begin
          ec = err_q.pop_front();
          check("err_cycle", cyc, ec);
          check("err_rdy", rdy, 1);
        end
      end
      prev_rdy = rdy;
    end
  end

  initial begin
    int l, a, p, e, d, total;
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_enables", {rd_en, we_a, we_b, err, res_b}, 0);
    check("rst_addr", {rd0, rd1, coef, wr0, wr1}, 0);
    check("rst_flags", {stage, st_zero, st_last, src_bank}, 0);
    rst = 1'b0;
    @(negedge clk);

    run(3, 0, 0);
    repeat (3) @(negedge clk);
    run(4, 0, 0);
    repeat (2) @(negedge clk);
    run(1, 0, 0);
    run(5, 0, 0);
    repeat (2) @(negedge clk);
    run(3, 8, 0);
    @(negedge clk);
    run(3, 0, 0);
    repeat (2) @(negedge clk);
    run(3, 0, 5);
    run(3, 0, 0);
    run(2, 0, 0);

    for (int it = 0; it < 30; it++) begin
      l = $urandom_range(0, 6);
      a = 0;
      p = 0;
      if (l >= 2 && l <= A_BIT) begin
        total = l * ((1 << (l - 1)) + LAT);
        if ($urandom_range(0, 3) == 0) a = $urandom_range(1, total - 1);
        if ($urandom_range(0, 1) == 1) p = $urandom_range(1, (a > 0) ? a : total - 1);
      end
      run(l, a, p);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Asynchronous reset mid-stage: outputs must clear before the next clock edge.
    e = cyc + 1;
    push_events(4, e, 0, d);
    log_n = 3'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rd_en", rd_en, 0);
    check("async_rst_rdy", rdy, 1);
    check("async_rst_addr", {rd0, rd1, coef, wr0, wr1}, 0);
    check("async_rst_flags", {we_a, we_b, stage, st_zero, src_bank}, 0);
    rd_q.delete();
    wr_q.delete();
    dn_q.delete();
    err_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(4, 0, 0);
    repeat (LAT + 2) @(negedge clk);

    check("rd_events_left", rd_q.size(), 0);
    check("wr_events_left", wr_q.size(), 0);
    check("done_events_left", dn_q.size(), 0);
    check("err_events_left", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
